// File: rtl/pc_pkg.sv
// pc_pkg: next-PC select encodings shared by the sequencer and its bench.
package pc_pkg;
  localparam int PS_W = 3;
  typedef enum logic [PS_W-1:0] {
    PS_HOLD = 3'b000,
    PS_INC  = 3'b001,
    PS_BR   = 3'b010,
    PS_JR   = 3'b011,
    PS_CALL = 3'b100,
    PS_RET  = 3'b101
  } ps_e;
endpackage

// File: rtl/return_stack.sv
// return_stack: circular return-address stack; a push when full overwrites the oldest entry.
module return_stack #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]     r_ptr;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;
  logic              r_unf;
  assign o_empty     = r_cnt == '0;
  assign o_full      = r_cnt == CW'(RAS_DEPTH);
  assign o_top       = r_mem[r_ptr - PW'(1)];
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;
  always_ff @(posedge clock)
    if (i_push) r_mem[r_ptr] <= i_data;
  // r_ptr is the next free slot; wrapping it lets a full push overwrite the oldest entry
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= i_push && o_full;
      r_unf <= i_pop && o_empty;
      if (i_push) begin
        r_ptr <= r_ptr + PW'(1);
        if (!o_full) r_cnt <= r_cnt + CW'(1);
      end else if (i_pop && !o_empty) begin
        r_ptr <= r_ptr - PW'(1);
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: LEGv8 program counter with branch/jump/call/return selection and a return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                OFF_W     = 26,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PS_W-1:0]   PS,
  input  logic              stall,
  input  logic [OFF_W-1:0]  offset,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PC4,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_bt;
  logic [ADDR_W-1:0] w_jt;
  logic [ADDR_W-1:0] w_top;
  logic [ADDR_W-1:0] w_next;
  logic              w_push;
  logic              w_pop;
  assign w_pc4  = r_pc + ADDR_W'(4);
  assign w_bt   = w_pc4 + (ADDR_W'($signed(offset)) << 2);
  assign w_jt   = target & ~ADDR_W'(3);
  assign w_push = reset && !stall && PS == PS_CALL;
  assign w_pop  = reset && !stall && PS == PS_RET;
  assign PC     = r_pc;
  assign PC4    = w_pc4;
  always_comb begin
    w_next = (PS == PS_INC) ? w_pc4 :
             (PS == PS_BR || PS == PS_CALL) ? w_bt :
             (PS == PS_JR) ? w_jt :
             (PS == PS_RET) ? (ras_empty ? w_pc4 : w_top) : r_pc;
  end
  always_ff @(posedge clock) begin
    if (!reset) r_pc <= RESET_PC;
    else if (!stall) r_pc <= w_next;
  end
  return_stack #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (w_pc4),
    .o_top       (w_top),
    .o_empty     (ras_empty),
    .o_full      (ras_full),
    .o_overflow  (ras_overflow),
    .o_underflow (ras_underflow)
  );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus random stimulus against a queue-based model of the sequencer.
module tb_pc_sequencer;
  import pc_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ps;
  logic        stall;
  logic [25:0] offset;
  logic [63:0] target;
  logic [63:0] pc, pc4;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] m_pc;
  logic [63:0] m_ras[$];
  logic        m_ovf, m_unf;

  pc_sequencer dut (
    .clock(clk), .reset(rst_n), .PS(ps), .stall(stall), .offset(offset), .target(target),
    .PC(pc), .PC4(pc4), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model(input logic rs, input logic [2:0] p, input logic st,
                       input logic [25:0] off, input logic [63:0] tgt);
    logic [63:0] nx4, bt;
    longint      so;
    nx4 = m_pc + 64'd4;
    so  = longint'($signed(off));
    bt  = nx4 + 64'(so * 4);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (!rs) begin
      m_pc = 64'h0;
      m_ras.delete();
    end else if (!st) begin
      case (p)
        3'd1: m_pc = nx4;
        3'd2: m_pc = bt;
        3'd3: m_pc = {tgt[63:2], 2'b00};
        3'd4: begin
          if (m_ras.size() == 4) begin
            m_ovf = 1'b1;
            void'(m_ras.pop_front());
          end
          m_ras.push_back(nx4);
          m_pc = bt;
        end
        3'd5: begin
          if (m_ras.size() == 0) begin
            m_unf = 1'b1;
            m_pc = nx4;
          end else m_pc = m_ras.pop_back();
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic rs, input logic [2:0] p, input logic st,
                      input logic [25:0] off, input logic [63:0] tgt);
    rst_n = rs; ps = p; stall = st; offset = off; target = tgt;
    @(posedge clk);
    #1;
    model(rs, p, st, off, tgt);
    chk("pc", pc, m_pc);
    chk("pc4", pc4, m_pc + 64'd4);
    chk("empty", 64'(ras_empty), 64'(m_ras.size() == 0));
    chk("full", 64'(ras_full), 64'(m_ras.size() == 4));
    chk("overflow", 64'(ras_overflow), 64'(m_ovf));
    chk("underflow", 64'(ras_underflow), 64'(m_unf));
  endtask

  initial begin
    m_pc = 64'h0; m_ovf = 1'b0; m_unf = 1'b0;
    step(1'b0, PS_INC, 1'b0, '0, '0);
    step(1'b0, PS_CALL, 1'b1, '0, '0);
    chk("reset_pc", pc, 64'h0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, PS_INC, 1'b0, '0, '0);
      chk("inc_pc", pc, 64'(4 * i));
    end
    step(1'b1, PS_JR, 1'b0, '0, 64'h100);
    step(1'b1, PS_BR, 1'b0, 26'h3FFFFFE, '0);
    chk("br_neg", pc, 64'hFC);
    step(1'b1, PS_JR, 1'b0, '0, 64'h100);
    step(1'b1, PS_BR, 1'b0, 26'd3, '0);
    chk("br_pos", pc, 64'h110);
    step(1'b1, PS_JR, 1'b0, '0, 64'h200);
    step(1'b1, PS_CALL, 1'b0, 26'h10, '0);
    chk("call_pc", pc, 64'h244);
    step(1'b1, PS_RET, 1'b0, '0, '0);
    chk("ret_pc", pc, 64'h204);
    chk("ret_empty", 64'(ras_empty), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, PS_CALL, 1'b0, '0, '0);
      chk("call5_ovf", 64'(ras_overflow), 64'(i == 4));
    end
    chk("call5_full", 64'(ras_full), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, PS_RET, 1'b0, '0, '0);
      chk("ret5_unf", 64'(ras_underflow), 64'(i == 4));
    end
    step(1'b1, PS_HOLD, 1'b0, '0, '0);
    chk("unf_clear", 64'(ras_underflow), 64'd0);
    step(1'b1, PS_JR, 1'b0, '0, 64'h1003);
    chk("jr_align", pc, 64'h1000);
    step(1'b1, PS_CALL, 1'b1, 26'h40, '0);
    chk("stall_pc", pc, 64'h1000);
    chk("stall_empty", 64'(ras_empty), 64'd1);
    step(1'b1, PS_CALL, 1'b0, '0, '0);
    step(1'b1, PS_CALL, 1'b0, '0, '0);
    step(1'b0, PS_INC, 1'b0, '0, '0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_empty", 64'(ras_empty), 64'd1);
    step(1'b1, PS_JR, 1'b0, '0, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, PS_INC, 1'b0, '0, '0);
    chk("wrap_pc", pc, 64'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(63) != 0, 3'($urandom_range(7)), $urandom_range(7) == 0,
           26'($urandom()), {$urandom(), $urandom()});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
